// File: rtl/elastic_mux.sv
// elastic_mux: registered valid/ready multiplexer for PE and switch-box use.
//   Selects one of NUM_INPUTS elastic streams and forwards it through a
//   single output register. Mode 0 forwards the configured channel only;
//   mode 1 merges all channels with a round-robin arbiter.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   config_en/sel/mode       configuration load (blocks input transfers that cycle)
//   in_data/in_valid         packed input channels, channel i at [i*DW +: DW]
//   in_ready                 per-channel ready (combinational, not a function of in_valid in static mode)
//   out_data/out_valid/out_src  registered output word, valid and source channel
//   out_ready                downstream ready
module elastic_mux #(
  parameter  int NUM_INPUTS = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             config_en,
  input  logic [SEL_W-1:0]                 config_sel,
  input  logic                             config_mode,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SEL_W-1:0]                 out_src
);

  logic [SEL_W-1:0]      r_sel;
  logic                  r_mode;
  logic [SEL_W-1:0]      r_rr_ptr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic [SEL_W-1:0]      r_out_src;

  logic                  w_load;
  logic                  w_sel_ok;
  logic [SEL_W:0]        w_idx;
  logic [SEL_W-1:0]      w_gnt;
  logic                  w_gnt_vld;
  logic [SEL_W-1:0]      w_pick;
  logic                  w_pick_ok;
  logic                  w_en;
  logic [NUM_INPUTS-1:0] w_ready;
  logic                  w_xfer;
  logic [SEL_W-1:0]      w_xfer_src;
  logic [DATA_WIDTH-1:0] w_din;

  // Output register can take a word when empty or draining this cycle.
  assign w_load   = !r_out_valid || out_ready;
  // Extra bit keeps the compare meaningful when NUM_INPUTS is a power of two.
  assign w_sel_ok = {1'b0, r_sel} < (SEL_W+1)'(NUM_INPUTS);

  // Round-robin: first valid channel at or after rr_ptr, wrapping.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
      if (w_idx >= (SEL_W+1)'(NUM_INPUTS))
        w_idx = w_idx - (SEL_W+1)'(NUM_INPUTS);
      if (!w_gnt_vld && in_valid[w_idx[SEL_W-1:0]]) begin
        w_gnt     = w_idx[SEL_W-1:0];
        w_gnt_vld = 1'b1;
      end
    end
  end

  assign w_pick    = r_mode ? w_gnt     : r_sel;
  assign w_pick_ok = r_mode ? w_gnt_vld : w_sel_ok;
  assign w_en      = !rst && w_load && !config_en && w_pick_ok;

  // Per-channel ready decode.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    assign w_ready[i] = w_en && (w_pick == SEL_W'(i));
  end
  assign in_ready = w_ready;

  // At most one ready bit is set, so an OR-style priority mux is exact.
  always_comb begin
    w_din      = '0;
    w_xfer_src = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_ready[i]) begin
        w_din      = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_xfer_src = SEL_W'(i);
      end
    end
  end

  assign w_xfer = |(in_valid & w_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel       <= '0;
      r_mode      <= 1'b0;
      r_rr_ptr    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
    end else begin
      if (config_en) begin
        r_sel    <= config_sel;
        r_mode   <= config_mode;
        r_rr_ptr <= '0;
      end else if (w_xfer && r_mode) begin
        r_rr_ptr <= (w_xfer_src == SEL_W'(NUM_INPUTS-1)) ? '0 : w_xfer_src + 1'b1;
      end

      if (w_xfer) begin
        r_out_data  <= w_din;
        r_out_src   <= w_xfer_src;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_elastic_mux.sv
// tb_elastic_mux: directed checks of elastic_mux with 4 channels (main DUT)
//   and 3 channels (out-of-range static select).
module tb_elastic_mux;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-channel instance
  logic          a_cfg_en, a_cfg_mode;
  logic [1:0]    a_cfg_sel;
  logic [4*DW-1:0] a_data;
  logic [3:0]    a_valid, a_ready;
  logic [DW-1:0] a_odata;
  logic          a_ovalid, a_ordy;
  logic [1:0]    a_osrc;

  // 3-channel instance
  logic          b_cfg_en, b_cfg_mode;
  logic [1:0]    b_cfg_sel;
  logic [3*DW-1:0] b_data;
  logic [2:0]    b_valid, b_ready;
  logic [DW-1:0] b_odata;
  logic          b_ovalid, b_ordy;
  logic [1:0]    b_osrc;

  elastic_mux #(.NUM_INPUTS(4), .DATA_WIDTH(DW)) u_dut4 (
    .clk(clk), .rst(rst),
    .config_en(a_cfg_en), .config_sel(a_cfg_sel), .config_mode(a_cfg_mode),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_ordy), .out_src(a_osrc)
  );

  elastic_mux #(.NUM_INPUTS(3), .DATA_WIDTH(DW)) u_dut3 (
    .clk(clk), .rst(rst),
    .config_en(b_cfg_en), .config_sel(b_cfg_sel), .config_mode(b_cfg_mode),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_ordy), .out_src(b_osrc)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_a(input logic [DW-1:0] d0, d1, d2, d3);
    a_data = {d3, d2, d1, d0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    int rr_a [5] = '{0, 1, 2, 3, 0};
    int rr_b [4] = '{1, 3, 1, 3};
    logic [3:0] exp_rdy;

    a_cfg_en = 0; a_cfg_sel = 0; a_cfg_mode = 0; a_valid = 4'hF; a_ordy = 1;
    set_a(32'h10, 32'h20, 32'h30, 32'h40);
    b_cfg_en = 0; b_cfg_sel = 0; b_cfg_mode = 0; b_valid = 3'b000; b_ordy = 1;
    b_data = {32'h300, 32'h200, 32'h100};

    // Reset state
    rst = 1;
    tick(); tick();
    chk("rst_ovalid", a_ovalid, 0);
    chk("rst_odata",  a_odata, 0);
    chk("rst_osrc",   a_osrc, 0);
    chk("rst_ready",  a_ready, 0);

    // Default static sel=0
    rst = 0; settle();
    chk("s0_ready", a_ready, 4'b0001);
    tick();
    chk("s0_data",  a_odata, 32'h10);
    chk("s0_valid", a_ovalid, 1);

    // Configure static sel=2; config cycle blocks inputs, output drains
    a_cfg_en = 1; a_cfg_sel = 2; settle();
    chk("cfg_ready", a_ready, 0);
    tick(); a_cfg_en = 0;
    chk("cfg_drain_valid", a_ovalid, 0);
    chk("cfg_hold_data",   a_odata, 32'h10);
    settle();
    chk("s2_ready", a_ready, 4'b0100);
    tick();
    chk("s2_data",  a_odata, 32'h30);
    chk("s2_src",   a_osrc, 2);
    chk("s2_valid", a_ovalid, 1);
    set_a(32'h10, 32'h20, 32'h31, 32'h40); settle();
    chk("s2_fill_ready", a_ready, 4'b0100);
    tick();
    chk("s2_data2", a_odata, 32'h31);

    // Backpressure on static sel=1
    a_cfg_en = 1; a_cfg_sel = 1; tick(); a_cfg_en = 0; settle();
    chk("s1_ready", a_ready, 4'b0010);
    tick();
    chk("s1_data", a_odata, 32'h20);
    chk("s1_src",  a_osrc, 1);
    a_ordy = 0; set_a(32'h10, 32'h21, 32'h30, 32'h40);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_ready", a_ready, 0);
      tick();
      chk("bp_data",  a_odata, 32'h20);
      chk("bp_valid", a_ovalid, 1);
    end
    a_ordy = 1; settle();
    chk("bp_rel_ready", a_ready, 4'b0010);
    tick();
    chk("bp_rel_data", a_odata, 32'h21);

    // Reconfigure to round-robin while output full and draining
    a_cfg_en = 1; a_cfg_mode = 1; a_cfg_sel = 3;
    set_a(32'h10, 32'h20, 32'h30, 32'h40); settle();
    chk("rr_cfg_ready", a_ready, 0);
    tick(); a_cfg_en = 0;
    chk("rr_cfg_drain", a_ovalid, 0);

    // All channels valid
    for (int i = 0; i < 5; i++) begin
      settle();
      exp_rdy = 4'b0001 << rr_a[i];
      chk("rr4_ready", a_ready, exp_rdy);
      tick();
      chk("rr4_src",  a_osrc, rr_a[i]);
      chk("rr4_data", a_odata, (rr_a[i] + 1) * 16);
    end

    // Only channels 1 and 3 valid
    a_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      settle();
      exp_rdy = 4'b0001 << rr_b[i];
      chk("rr13_ready", a_ready, exp_rdy);
      tick();
      chk("rr13_src",  a_osrc, rr_b[i]);
      chk("rr13_data", a_odata, (rr_b[i] + 1) * 16);
    end

    // No valid inputs: no grant, output drains
    a_valid = 4'b0000; settle();
    chk("rr_idle_ready", a_ready, 0);
    tick();
    chk("rr_idle_valid", a_ovalid, 0);

    // Reset mid-stream
    a_valid = 4'hF; tick();
    chk("pre_rst_valid", a_ovalid, 1);
    chk("pre_rst_src",   a_osrc, 0);
    rst = 1; settle();
    chk("mid_rst_valid", a_ovalid, 0);
    chk("mid_rst_data",  a_odata, 0);
    chk("mid_rst_src",   a_osrc, 0);
    chk("mid_rst_ready", a_ready, 0);
    tick(); rst = 0; settle();
    chk("post_rst_ready", a_ready, 4'b0001);

    // 3-channel instance: out-of-range static select
    b_valid = 3'b111; settle();
    chk("b_s0_ready", b_ready, 3'b001);
    tick();
    chk("b_s0_valid", b_ovalid, 1);
    chk("b_s0_data",  b_odata, 32'h100);
    b_cfg_en = 1; b_cfg_sel = 3; settle();
    chk("b_cfg_ready", b_ready, 0);
    tick(); b_cfg_en = 0;
    chk("b_drain_valid", b_ovalid, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("b_oor_ready", b_ready, 0);
      tick();
      chk("b_oor_valid", b_ovalid, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/elastic_mux.md
Name: elastic_mux

Overview:
- Registered, handshaked successor to the plain combinational CGRA multiplexer.
- Selects one of NUM_INPUTS valid/ready data streams and forwards it through a single output register stage.
- Two modes:
  - Static: the configured input only.
  - Round-robin merge: fair arbitration among all valid inputs.
- Used inside PE and interconnect switch boxes where the elastic valid/ready protocol must be preserved across the mux.

Parameters:
- NUM_INPUTS, 4, number of input channels (>=1).
- DATA_WIDTH, 32, width of each data channel in bits.
- SEL_W, derived (localparam, not overridable), max(1, $clog2(NUM_INPUTS)), width of select/source fields.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- config_en  input  1  load config_sel/config_mode this cycle.
- config_sel  input  SEL_W  static-mode input index.
- config_mode  input  1  0 = static select, 1 = round-robin merge.
- in_data  input  NUM_INPUTS*DATA_WIDTH  packed inputs; channel i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- in_valid  input  NUM_INPUTS  per-channel valid.
- in_ready  output  NUM_INPUTS  per-channel ready (combinational).
- out_data  output  DATA_WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_src  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (async, immediate) clears all state:
  - out_valid=0, out_data=0, out_src=0.
  - Configured sel=0, configured mode=0, round-robin pointer rr_ptr=0.
  - in_ready=0 while rst is high.
- Configuration:
  - On a clk edge with config_en=1, sel<=config_sel and mode<=config_mode; rr_ptr<=0.
  - During a config_en cycle all in_ready=0, so no input transfer occurs.
  - The output register is unaffected by config_en: it still drains on out_ready.
- load = !out_valid || out_ready.
- Static mode (mode=0):
  - in_ready[i] = load && !config_en && (i==sel). in_ready must not depend on in_valid.
  - If sel >= NUM_INPUTS, all in_ready=0. The output drains and then stays empty.
- Round-robin mode (mode=1):
  - grant = first index g with in_valid[g]=1, searching rr_ptr, rr_ptr+1, ..., wrapping at NUM_INPUTS.
  - in_ready[grant] = load && !config_en; all other in_ready=0.
  - If no input is valid, there is no grant and all in_ready=0.
  - After each transfer, rr_ptr <= grant+1, wrapping to 0 when equal to NUM_INPUTS. rr_ptr is unchanged when no transfer occurs.
  - configured sel is ignored in this mode.
- Transfer on channel k occurs when in_valid[k] && in_ready[k]. At most one transfer per cycle. Next edge:
  - out_data <= channel k data.
  - out_src <= k.
  - out_valid <= 1.
- No transfer and out_ready=1: out_valid <= 0. out_data and out_src hold their last value.
- No transfer and out_ready=0: all output state holds. Data must stay stable while out_valid && !out_ready.
- Timing:
  - Latency: 1 cycle, input handshake to out_valid.
  - Throughput: 1 word/cycle with out_ready held high (simultaneous drain and fill).
- Simultaneous config_en and out_ready: the output drains normally; new config applies from the next cycle.
- Reset mid-stream: in-flight output data is discarded with no handshake. The upstream word is not consumed unless the edge preceded reset.
- NUM_INPUTS=1: SEL_W=1; sel=1 is out of range, so static mode blocks; round-robin always grants channel 0.
- No combinational path from in_data to out_data. out_ready -> in_ready path is allowed.

Test Plan:
- Reset checks:
  - Assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_src=0 immediately, before the next edge.
  - After release, static sel=0 is active.
- Static sel=2 with all in_valid=1:
  - Data channels 0..3 = 0x10, 0x20, 0x30, 0x40; out_ready=1.
  - in_ready=4'b0100.
  - out_data=0x30, out_src=2 one cycle later, one word per cycle.
- Backpressure in static sel=1:
  - out_ready=0 for 3 cycles with out_valid=1.
  - in_ready=0; out_data stable for all 3 cycles.
  - out_ready=1 -> new word accepted the same cycle.
- Round-robin:
  - All 4 valid continuously, out_ready=1.
  - out_src sequence 0,1,2,3,0.
  - Then only channels 1 and 3 valid: sequence 1,3,1,3.
- Reconfiguration:
  - config_en with mode=1 while out_valid=1 and out_ready=1.
  - in_ready=0 that cycle; the word drains; arbitration starts at channel 0 the next cycle.
- Out-of-range static selection:
  - NUM_INPUTS=3, sel=3 with all inputs valid.
  - in_ready=0 forever; out_valid=0 after drain.
